spi_slave_word: RTL and testbench

- Parametrised successor to the team's byte-wide receive-only SPI slave.
- Full-duplex SPI slave with configurable word width, all four CPOL/CPHA modes and selectable bit order.
- On-chip metastability synchronisers for the SPI inputs; MISO transmit path with a valid/ready load handshake; partial-word abort reporting.
- Sits between an external SPI master (e.g. host MCU) and the display/register logic in the clk domain.

---
 rtl/spi_slave_word.sv | 206 ++++++++++++++++++++
 tb/tb_spi_slave_word.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// Full-duplex SPI slave with parametrised word width, CPOL/CPHA mode and bit order.
// SPI pins are synchronised into clk; received words and tx loads are reported as clk-domain pulses.
`timescale 1ns/1ps
module spi_slave_word #(
  parameter int              WIDTH     = 8,
  parameter bit              CPOL      = 1'b0,
  parameter bit              CPHA      = 1'b0,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] TX_IDLE  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_first,
  output logic             rx_abort,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  // Bit order of the preset vector: {mosi, cs, clk}
  localparam logic [2:0] SYNC_PRESET = {1'b0, 1'b1, CPOL};

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    if (MSB_FIRST) return {w[WIDTH-2:0], b};
    return {b, w[WIDTH-1:1]};
  endfunction

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    return {1'b0, w[WIDTH-1:1]};
  endfunction

  logic [2:0] raw_in;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic       sclk_d_reg;
  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;

  assign raw_in = {spi_mosi, spi_cs, spi_clk};
  assign sclk_s = sync2_reg[0];
  assign cs_s   = sync2_reg[1];
  assign mosi_s = sync2_reg[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= SYNC_PRESET;
      sync2_reg  <= SYNC_PRESET;
      sclk_d_reg <= CPOL;
    end else begin
      sync1_reg  <= raw_in;
      sync2_reg  <= sync1_reg;
      sclk_d_reg <= sclk_s;
    end
  end

  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;

  assign lead_edge   = (sclk_d_reg == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_d_reg != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  state_t           state_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic             first_reg;
  logic             word_done_reg;
  logic             need_load_reg;
  logic [WIDTH-1:0] rx_sh_reg;
  logic [WIDTH-1:0] tx_sh_reg;
  logic             miso_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg;
  logic             rx_first_reg;
  logic             rx_abort_reg;
  logic             tx_ready_reg;
  logic             tx_underrun_reg;
  logic             busy_reg;

  logic             load_now;
  logic             adv_now;
  logic [WIDTH-1:0] load_word;

  assign load_word = tx_valid ? tx_data : TX_IDLE;

  // A load replaces the shift-edge advance: CPHA=0 loads once at selection and after each
  // completed word, CPHA=1 loads on the leading edge that starts every word.
  always_comb begin
    load_now = 1'b0;
    adv_now  = 1'b0;
    if (state_reg == S_IDLE) begin
      load_now = !cs_s && !CPHA;
    end else if (!cs_s && shift_edge) begin
      if (CPHA ? (bit_cnt_reg == '0) : need_load_reg) load_now = 1'b1;
      else                                            adv_now  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      bit_cnt_reg     <= '0;
      first_reg       <= 1'b0;
      word_done_reg   <= 1'b0;
      need_load_reg   <= 1'b0;
      rx_sh_reg       <= '0;
      tx_sh_reg       <= '0;
      miso_reg        <= first_bit(TX_IDLE);
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_first_reg    <= 1'b0;
      rx_abort_reg    <= 1'b0;
      tx_ready_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      busy_reg        <= !cs_s;
      rx_abort_reg    <= 1'b0;
      word_done_reg   <= 1'b0;
      tx_ready_reg    <= load_now && tx_valid;
      tx_underrun_reg <= load_now && !tx_valid;

      // Word completion is independent of the state so that a deselect right after
      // the last sample still delivers the word.
      rx_valid_reg <= word_done_reg;
      rx_first_reg <= word_done_reg && first_reg;
      if (word_done_reg) begin
        rx_data_reg <= rx_sh_reg;
        first_reg   <= 1'b0;
      end

      if (load_now) begin
        tx_sh_reg <= load_word;
        miso_reg  <= first_bit(load_word);
      end else if (adv_now) begin
        tx_sh_reg <= advance(tx_sh_reg);
        miso_reg  <= first_bit(advance(tx_sh_reg));
      end

      case (state_reg)
        S_IDLE: begin
          if (!cs_s) begin
            state_reg     <= S_ACTIVE;
            bit_cnt_reg   <= '0;
            first_reg     <= 1'b1;
            need_load_reg <= 1'b0;
            rx_sh_reg     <= '0;
          end
        end
        S_ACTIVE: begin
          if (cs_s) begin
            state_reg     <= S_IDLE;
            rx_abort_reg  <= (bit_cnt_reg != '0);
            bit_cnt_reg   <= '0;
            need_load_reg <= 1'b0;
          end else if (sample_edge) begin
            rx_sh_reg <= shift_in(rx_sh_reg, mosi_s);
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_reg   <= '0;
              word_done_reg <= 1'b1;
              need_load_reg <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
          end else if (shift_edge && load_now) begin
            need_load_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_reg;
  assign spi_miso_oe = busy_reg;
  assign busy        = busy_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign rx_first    = rx_first_reg;
  assign rx_abort    = rx_abort_reg;
  assign tx_ready    = tx_ready_reg;
  assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: six instances covering all modes, both bit orders and a 16-bit word,
// driven by a behavioural SPI master and checked against a per-transfer word-level model.
`timescale 1ns/1ps
module tb_spi_slave_word;

  localparam int N_INST = 6;
  localparam int P_W    [6] = '{8, 8, 8, 8, 8, 16};
  localparam bit P_CPOL [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit P_CPHA [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit P_MSB  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    int          inst;
    logic [15:0] data;
    logic        first;
    longint      t;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] sclk, cs, mosi, tx_valid;
  logic [5:0] miso, oe, rx_valid, rx_first, rx_abort, tx_ready, tx_under, busy;
  logic [15:0] rx_data_a [6];
  logic [15:0] tx_data_a [6];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
    localparam int W = P_W[gi];
    logic [W-1:0] rxd;
    spi_slave_word #(
      .WIDTH(W), .CPOL(P_CPOL[gi]), .CPHA(P_CPHA[gi]), .MSB_FIRST(P_MSB[gi])
    ) u_dut (
      .clk(clk), .rst(rst),
      .spi_clk(sclk[gi]), .spi_cs(cs[gi]), .spi_mosi(mosi[gi]),
      .spi_miso(miso[gi]), .spi_miso_oe(oe[gi]),
      .rx_data(rxd), .rx_valid(rx_valid[gi]), .rx_first(rx_first[gi]), .rx_abort(rx_abort[gi]),
      .tx_data(tx_data_a[gi][W-1:0]), .tx_valid(tx_valid[gi]), .tx_ready(tx_ready[gi]),
      .tx_underrun(tx_under[gi]), .busy(busy[gi])
    );
    assign rx_data_a[gi] = 16'(rxd);
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shared state between the master (main initial) and the monitor/producer block
  int          cur = 0;
  int          tx_base = 0;
  int          tx_k = 0;
  logic [15:0] mw [4];
  logic [15:0] tw [8];

  ev_t evq[$];
  int  n_ready [6];
  int  n_under [6];
  int  n_abort [6];
  int  n_both  = 0;
  int  n_taken = 0;

  always @(negedge clk) begin
    int idx;
    for (int i = 0; i < N_INST; i++) begin
      if (rx_valid[i]) evq.push_back('{i, rx_data_a[i], rx_first[i], longint'($time) - 5});
      if (tx_ready[i]) n_ready[i]++;
      if (tx_under[i]) n_under[i]++;
      if (tx_ready[i] && tx_under[i]) n_both++;
      if (rx_abort[i]) n_abort[i]++;
    end
    if (tx_ready[cur]) n_taken++;
    idx = n_taken - tx_base;
    for (int i = 0; i < N_INST; i++) begin
      tx_valid[i]  = (i == cur) && (idx < tx_k);
      tx_data_a[i] = (i == cur && idx < 8) ? tw[idx] : 16'h0;
    end
  end

  function automatic logic wire_bit(input logic [15:0] word, input int pos, input int i);
    if (P_MSB[i]) return word[P_W[i] - 1 - pos];
    return word[pos];
  endfunction

  // endm: 0 = normal end, 1 = raise cs 1 clk after the last sample (mode 0 only), 2 = stay selected
  task automatic xfer(input int i, input int nbits, input int k, input int endm, input int h);
    int          w, nw, loads, tcnt, exp_rdy, ev0, rdy0, und0, ab0, both0;
    logic [15:0] mask, rx_prev, exp_rx, got_w, exp_w, src;
    logic        rd [64];
    longint      st [64];
    longint      el;
    w    = P_W[i];
    mask = 16'((32'd1 << w) - 1);
    @(posedge clk);
    cur = i; tx_base = n_taken; tx_k = k;
    @(negedge clk); @(negedge clk);
    ev0 = evq.size(); rdy0 = n_ready[i]; und0 = n_under[i]; ab0 = n_abort[i]; both0 = n_both;
    rx_prev = rx_data_a[i];
    @(posedge clk);
    #($urandom_range(1, 9));
    cs[i] = 1'b0;
    if (!P_CPHA[i]) mosi[i] = wire_bit(mw[0], 0, i);
    #(h);
    check("busy_on", {busy[i], oe[i]}, 2'b11);
    for (int b = 0; b < nbits; b++) begin
      if (!P_CPHA[i]) begin
        rd[b] = miso[i]; sclk[i] = ~sclk[i]; st[b] = $time;
        if (endm == 1 && b == nbits - 1) begin
          #10; cs[i] = 1'b1;
        end else begin
          #(h);
          sclk[i] = ~sclk[i];
          if (b + 1 < nbits) mosi[i] = wire_bit(mw[(b + 1) / w], (b + 1) % w, i);
          #(h);
        end
      end else begin
        sclk[i] = ~sclk[i]; mosi[i] = wire_bit(mw[b / w], b % w, i); #(h);
        rd[b] = miso[i]; sclk[i] = ~sclk[i]; st[b] = $time; #(h);
      end
    end
    if (endm == 2) return;
    if (endm != 1) cs[i] = 1'b1;
    #(h);
    sclk[i] = P_CPOL[i];
    repeat (8) @(negedge clk);

    nw = nbits / w;
    check("rx_count", evq.size() - ev0, nw);
    for (int j = 0; j < nw && ev0 + j < evq.size(); j++) begin
      check("rx_inst", evq[ev0 + j].inst, i);
      check("rx_data", evq[ev0 + j].data, mw[j] & mask);
      check("rx_first", evq[ev0 + j].first, (j == 0));
      el = evq[ev0 + j].t - st[(j + 1) * w - 1];
      check("rx_latency", (el > 30 && el <= 40), 1'b1);
    end
    exp_rx = (nw > 0) ? (mw[nw - 1] & mask) : rx_prev;
    check("rx_data_hold", rx_data_a[i], exp_rx);
    check("rx_abort", n_abort[i] - ab0, (nbits % w) != 0);

    if (P_CPHA[i]) loads = (nbits + w - 1) / w;
    else begin
      tcnt  = (endm == 1) ? nbits - 1 : nbits;
      loads = 1 + tcnt / w;
    end
    exp_rdy = (loads < k) ? loads : k;
    check("tx_ready", n_ready[i] - rdy0, exp_rdy);
    check("tx_underrun", n_under[i] - und0, loads - exp_rdy);
    check("tx_both", n_both - both0, 0);

    for (int j = 0; j * w < nbits; j++) begin
      src   = (j < k) ? tw[j] : 16'hFFFF;
      got_w = '0; exp_w = '0;
      for (int p = 0; p < w && j * w + p < nbits; p++) begin
        got_w[p] = rd[j * w + p];
        exp_w[p] = wire_bit(src, p, i);
      end
      check("miso_word", got_w, exp_w);
    end
    check("busy_off", {busy[i], oe[i]}, 2'b00);
    $display("xfer inst=%0d bits=%0d words=%0d tx_words=%0d loads=%0d rx_data=%0h",
             i, nbits, nw, k, loads, rx_data_a[i]);
  endtask

  initial begin
    int words, i, nw, nbits, k, ab0, ev0;
    cs = '1; mosi = '0;
    for (int j = 0; j < N_INST; j++) sclk[j] = P_CPOL[j];
    for (int j = 0; j < N_INST; j++) begin n_ready[j] = 0; n_under[j] = 0; n_abort[j] = 0; end

    #22;
    check("rst_pulses", {rx_valid, rx_first, rx_abort, tx_ready, tx_under}, 30'h0);
    check("rst_busy", {busy, oe}, 12'h0);
    check("rst_miso", miso, 6'h3F);
    for (int j = 0; j < N_INST; j++) check("rst_rx_data", rx_data_a[j], 16'h0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    mw[0] = 16'hA5; tw[0] = 16'h3C;
    xfer(0, 8, 1, 0, 40);

    for (int j = 1; j <= 4; j++) begin
      mw[0] = 16'h81; mw[1] = 16'h7E;
      tw[0] = 16'($urandom); tw[1] = 16'($urandom);
      xfer(j, 16, 2, 0, 40);
    end

    mw[0] = 16'hBEEF;
    xfer(5, 16, 0, 0, 50);

    mw[0] = 16'hFF; tw[0] = 16'h55;
    xfer(0, 5, 1, 0, 40);
    mw[0] = 16'h12; tw[0] = 16'hC3;
    xfer(0, 8, 1, 0, 40);

    mw[0] = 16'($urandom); tw[0] = 16'($urandom);
    xfer(0, 8, 1, 1, 40);

    mw[0] = 16'hF0; tw[0] = 16'h0F;
    xfer(0, 4, 1, 2, 50);
    ab0 = n_abort[0]; ev0 = evq.size();
    #3 rst = 1'b1;
    #1;
    check("midrst_pulses", {rx_valid[0], rx_first[0], rx_abort[0], tx_ready[0], tx_under[0]}, 5'h0);
    check("midrst_busy", {busy[0], oe[0]}, 2'b00);
    check("midrst_rx_data", rx_data_a[0], 16'h0);
    check("midrst_miso", miso[0], 1'b1);
    cs[0] = 1'b1; sclk[0] = P_CPOL[0];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_abort", n_abort[0] - ab0, 0);
    check("midrst_no_rx", evq.size() - ev0, 0);
    mw[0] = 16'h69; tw[0] = 16'h96;
    xfer(0, 8, 1, 0, 40);

    words = 0;
    while (words < 100) begin
      i     = $urandom_range(0, N_INST - 1);
      nw    = $urandom_range(1, 3);
      nbits = nw * P_W[i];
      if ($urandom_range(0, 4) == 0) nbits -= $urandom_range(1, P_W[i] - 1);
      k = $urandom_range(0, 4);
      for (int j = 0; j < 4; j++) mw[j] = 16'($urandom);
      for (int j = 0; j < 8; j++) tw[j] = 16'($urandom);
      xfer(i, nbits, k, 0, 40 + 10 * $urandom_range(0, 2));
      words += nbits / P_W[i];
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
